// File: rtl/ahbl_gpio_pkg.sv
// Shared constants for the AHB-Lite GPIO bank: register word offsets (HADDR[4:2]),
// HTRANS encodings and the OKAY response code.
package ahbl_gpio_pkg;

  localparam logic [2:0] OFF_DATAIN  = 3'd0;
  localparam logic [2:0] OFF_DATAOUT = 3'd1;
  localparam logic [2:0] OFF_DIR     = 3'd2;
  localparam logic [2:0] OFF_IM      = 3'd3;
  localparam logic [2:0] OFF_EDGE    = 3'd4;
  localparam logic [2:0] OFF_POL     = 3'd5;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY = 1'b0;

endpackage

// File: rtl/gpio_sync.sv
// Vector-wide STAGES-deep flop synchronizer for asynchronous pad inputs.
// Latency STAGES cycles; no flow control. Synchronous active-high reset clears every stage.
module gpio_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/ahbl_gpio.sv
// AHB-Lite zero-wait-state GPIO bank (out, oe, synchronized in); writes land 1 cycle after accept, never stalls.
// Edge detect / IM / EDGE / POL / IRQ are built only when AHBL_GPIO_IRQ_EN is defined.
module ahbl_gpio
  import ahbl_gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic             HREADY,
  input  logic [31:0]      HWDATA,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic [WIDTH-1:0] GPIO_OUT,
  output logic [WIDTH-1:0] GPIO_OE,
  input  logic [WIDTH-1:0] GPIO_IN,
  output logic             IRQ
);

  logic             w_accept;
  logic [WIDTH-1:0] w_wdat;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rd;
  logic             w_unused;

  logic             r_we;
  logic             r_re;
  logic [2:0]       r_off;
  logic [WIDTH-1:0] r_dataout;
  logic [WIDTH-1:0] r_dir;

  assign w_accept  = HSEL & HTRANS[1] & HREADY;
  assign w_wdat    = HWDATA[WIDTH-1:0];
  assign HREADYOUT = 1'b1;
  assign HRESP     = HRESP_OKAY;
  assign GPIO_OUT  = r_dataout;
  assign GPIO_OE   = r_dir;
  assign w_unused  = ^{HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

  gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .i_clk (HCLK),
    .i_rst (HRESET),
    .i_d   (GPIO_IN),
    .o_q   (w_sync)
  );

  // Reset takes priority, so a transfer whose data phase overlaps reset is dropped.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_off     <= '0;
      r_dataout <= '0;
      r_dir     <= '0;
    end else begin
      r_we <= w_accept & HWRITE;
      r_re <= w_accept & ~HWRITE;
      if (w_accept) r_off <= HADDR[4:2];
      if (r_we && r_off == OFF_DATAOUT) r_dataout <= w_wdat;
      if (r_we && r_off == OFF_DIR)     r_dir     <= w_wdat;
    end
  end

`ifdef AHBL_GPIO_IRQ_EN
  logic [WIDTH-1:0] r_sync_d;
  logic [WIDTH-1:0] r_im;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_pol;
  logic             r_irq;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_clr;

  assign w_event = (~r_pol & w_sync & ~r_sync_d) | (r_pol & ~w_sync & r_sync_d);
  assign w_clr   = (r_we && r_off == OFF_EDGE) ? w_wdat : '0;

  // A fresh event beats a simultaneous W1C so no edge is ever lost.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_sync_d <= '0;
      r_im     <= '0;
      r_edge   <= '0;
      r_pol    <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_sync_d <= w_sync;
      if (r_we && r_off == OFF_IM)  r_im  <= w_wdat;
      if (r_we && r_off == OFF_POL) r_pol <= w_wdat;
      r_edge <= (r_edge & ~w_clr) | w_event;
      r_irq  <= |(r_edge & r_im);
    end
  end

  assign IRQ = r_irq;
`else
  assign IRQ = 1'b0;
`endif

  always_comb begin
    w_rd   = '0;
    HRDATA = '0;
    if (r_re) begin
      case (r_off)
        OFF_DATAIN:  w_rd = w_sync;
        OFF_DATAOUT: w_rd = r_dataout;
        OFF_DIR:     w_rd = r_dir;
`ifdef AHBL_GPIO_IRQ_EN
        OFF_IM:      w_rd = r_im;
        OFF_EDGE:    w_rd = r_edge;
        OFF_POL:     w_rd = r_pol;
`endif
        default:     w_rd = '0;
      endcase
    end
    HRDATA[WIDTH-1:0] = w_rd;
  end

endmodule

// File: tb/tb_ahbl_gpio.sv
// Bench for ahbl_gpio: driver steps a cycle-level reference model and queues expected read data;
// a bus monitor pops and compares in each read data phase and checks the pad/IRQ outputs every cycle.
module tb_ahbl_gpio;

  localparam int WIDTH = 32;
  localparam int SS    = 2;
`ifdef AHBL_GPIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic             HCLK;
  logic             HRESET;
  logic             HSEL;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic             HWRITE;
  logic [2:0]       HSIZE;
  logic             HREADY;
  logic [31:0]      HWDATA;
  logic [31:0]      HRDATA;
  logic             HREADYOUT;
  logic             HRESP;
  logic [WIDTH-1:0] GPIO_OUT;
  logic [WIDTH-1:0] GPIO_OE;
  logic [WIDTH-1:0] GPIO_IN;
  logic             IRQ;

  ahbl_gpio #(.WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HREADY    (HREADY),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .GPIO_OUT  (GPIO_OUT),
    .GPIO_OE   (GPIO_OE),
    .GPIO_IN   (GPIO_IN),
    .IRQ       (IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0]      exp_q [$];
  logic [WIDTH-1:0] hist  [$];   // pin values applied each cycle since the last reset
  logic [WIDTH-1:0] m_out, m_dir, m_im, m_edge, m_pol;
  logic             m_irq;
  bit               pend_wr;
  logic [2:0]       pend_off;
  logic [31:0]      pend_wdata;
  bit               mon_on;
  bit               mon_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Synchronized pin value 'back' cycles before the current point: pins appear SS cycles late, 0 after reset.
  function automatic logic [WIDTH-1:0] sync_val(input int back);
    int idx;
    idx = hist.size() - SS - back;
    return (idx >= 0) ? hist[idx] : '0;
  endfunction

  function automatic logic [31:0] rd_model(input logic [2:0] off);
    logic [31:0] v;
    v = '0;
    case (off)
      3'd0: v[WIDTH-1:0] = sync_val(0);
      3'd1: v[WIDTH-1:0] = m_out;
      3'd2: v[WIDTH-1:0] = m_dir;
      3'd3: v[WIDTH-1:0] = m_im;
      3'd4: v[WIDTH-1:0] = m_edge;
      3'd5: v[WIDTH-1:0] = m_pol;
      default: v = '0;
    endcase
    return v;
  endfunction

  // One bus cycle: address phase for this op, data phase for the previous one; model advances across the edge.
  task automatic step(input bit vld, input bit wr, input logic [2:0] off, input logic [31:0] wd,
                      input logic [WIDTH-1:0] pins, input bit rdy = 1'b1, input bit rst = 1'b0);
    logic [31:0]      a;
    logic [WIDTH-1:0] cur, prv, ev, clr, wdw;
    logic [WIDTH-1:0] n_out, n_dir, n_im, n_edge, n_pol;
    logic             n_irq;
    a       = $urandom();
    a[4:2]  = off;
    HRESET  = rst;
    HSEL    = vld;
    HTRANS  = vld ? ($urandom_range(0, 1) ? 2'b10 : 2'b11) : ($urandom_range(0, 1) ? 2'b00 : 2'b01);
    HADDR   = a;
    HWRITE  = wr;
    HSIZE   = 3'($urandom());
    HREADY  = rdy;
    HWDATA  = pend_wr ? pend_wdata : $urandom();
    GPIO_IN = pins;
    n_out = m_out; n_dir = m_dir; n_im = m_im; n_edge = m_edge; n_pol = m_pol; n_irq = 1'b0;
    if (rst) begin
      n_out = '0; n_dir = '0; n_im = '0; n_edge = '0; n_pol = '0;
      hist.delete();
    end else begin
      hist.push_back(pins);
      cur = sync_val(1);
      prv = sync_val(2);
      ev  = IRQ_EN ? ((~m_pol & cur & ~prv) | (m_pol & ~cur & prv)) : '0;
      clr = '0;
      wdw = pend_wdata[WIDTH-1:0];
      if (pend_wr) begin
        case (pend_off)
          3'd1: n_out = wdw;
          3'd2: n_dir = wdw;
          3'd3: if (IRQ_EN) n_im = wdw;
          3'd4: if (IRQ_EN) clr = wdw;
          3'd5: if (IRQ_EN) n_pol = wdw;
          default: ;
        endcase
      end
      n_edge = (m_edge & ~clr) | ev;
      n_irq  = IRQ_EN && (|(m_edge & m_im));
    end
    @(posedge HCLK);
    #1;
    m_out = n_out; m_dir = n_dir; m_im = n_im; m_edge = n_edge; m_pol = n_pol; m_irq = n_irq;
    pend_wr    = !rst && vld && rdy && wr;
    pend_off   = off;
    pend_wdata = wd;
    if (!rst && vld && rdy && !wr) exp_q.push_back(rd_model(off));
  endtask

  // Bus-side view of when a read data phase is in progress.
  always @(posedge HCLK) mon_rd <= !HRESET && HSEL && HTRANS[1] && HREADY && !HWRITE;

  always @(negedge HCLK) begin
    if (mon_on) begin
      if (mon_rd) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rdata: read data phase with no expected value, got %h", HRDATA);
        end else begin
          chk("rdata", HRDATA, exp_q.pop_front());
        end
      end else begin
        chk("rdata_idle", HRDATA, 32'h0);
      end
      chk("gpio_out", GPIO_OUT, m_out);
      chk("gpio_oe", GPIO_OE, m_dir);
      chk("irq", {31'h0, IRQ}, {31'h0, m_irq});
      chk("hreadyout", {31'h0, HREADYOUT}, 32'h1);
      chk("hresp", {31'h0, HRESP}, 32'h0);
    end
  end

  logic [WIDTH-1:0] pins;

  initial begin
    pins = '0;
    pend_wr = 1'b0; pend_off = '0; pend_wdata = '0;
    m_out = '0; m_dir = '0; m_im = '0; m_edge = '0; m_pol = '0; m_irq = 1'b0;
    mon_on = 1'b0;

    repeat (3) step(0, 0, 3'd0, 32'h0, pins, 1, 1);
    mon_on = 1'b1;
    step(1, 0, 3'd1, 32'h0, pins);

    // Output path and readback.
    step(1, 1, 3'd1, 32'hF00FE00E, pins);
    step(1, 1, 3'd2, 32'hFFFFFFFF, pins);
    step(1, 0, 3'd1, 32'h0, pins);
    step(1, 0, 3'd2, 32'h0, pins);

    // Input latency: DATAIN polled every cycle around the change.
    step(1, 1, 3'd2, 32'h0, pins);
    pins = 32'h000000A5;
    for (int i = 0; i < SS + 3; i++) step(1, 0, 3'd0, 32'h0, pins);

    // Edge interrupt, rising then falling polarity.
    step(1, 1, 3'd4, 32'hFFFFFFFF, pins);
    pins = '0;
    for (int i = 0; i < SS + 2; i++) step(0, 0, 3'd0, 32'h0, pins);
    step(1, 1, 3'd4, 32'hFFFFFFFF, pins);
    step(1, 1, 3'd3, 32'h1, pins);
    step(1, 1, 3'd5, 32'h0, pins);
    pins = 32'h1;
    for (int i = 0; i < SS + 3; i++) step(0, 0, 3'd0, 32'h0, pins);
    step(1, 0, 3'd4, 32'h0, pins);
    step(1, 1, 3'd4, 32'h1, pins);
    step(0, 0, 3'd0, 32'h0, pins);
    step(1, 0, 3'd4, 32'h0, pins);
    step(1, 1, 3'd5, 32'h1, pins);
    pins = '0;
    for (int i = 0; i < SS + 3; i++) step(0, 0, 3'd0, 32'h0, pins);
    step(1, 0, 3'd4, 32'h0, pins);

    // Clear/set collision: W1C data phase lands on the edge that detects a new rise.
    step(1, 1, 3'd5, 32'h0, pins);
    pins = 32'h1;
    step(0, 0, 3'd0, 32'h0, pins);
    for (int i = 0; i < SS - 2; i++) step(0, 0, 3'd0, 32'h0, pins);
    step(1, 1, 3'd4, 32'h1, pins);
    step(0, 0, 3'd0, 32'h0, pins);
    step(1, 0, 3'd4, 32'h0, pins);
    step(0, 0, 3'd0, 32'h0, pins);

    // Back-to-back write/read and unmapped offsets.
    step(1, 1, 3'd1, 32'h12345678, pins);
    step(1, 0, 3'd1, 32'h0, pins);
    step(1, 0, 3'd7, 32'h0, pins);
    step(1, 1, 3'd6, 32'hFFFFFFFF, pins);
    step(1, 0, 3'd6, 32'h0, pins);

    // Reset during a write data phase drops the write.
    step(1, 1, 3'd1, 32'hDEADBEEF, pins);
    step(0, 0, 3'd0, 32'h0, pins, 1, 1);
    step(1, 0, 3'd1, 32'h0, pins);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      int b;
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom_range(0, WIDTH - 1);
        pins[b] = ~pins[b];
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
           $urandom(), pins, $urandom_range(0, 7) != 0, $urandom_range(0, 299) == 0);
    end

    repeat (3) step(0, 0, 3'd0, 32'h0, pins);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
